// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
//   Shared definitions for the 480x272 RGB LCD raster generator:
//   - panel timing constants (active, porch and sync widths, sync polarity)
//   - the controller state enum {IDLE, RUN, DRAIN}
//   - span_total(): total length of one axis (active + porches + sync)
package lcd_timing_pkg;

  localparam int PANEL_H_ACTIVE = 480;
  localparam int PANEL_H_FP     = 2;
  localparam int PANEL_H_SYNC   = 41;
  localparam int PANEL_H_BP     = 2;
  localparam int PANEL_V_ACTIVE = 272;
  localparam int PANEL_V_FP     = 2;
  localparam int PANEL_V_SYNC   = 10;
  localparam int PANEL_V_BP     = 2;
  localparam int PANEL_HS_POL   = 0;
  localparam int PANEL_VS_POL   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lcd_span_counter.sv
// lcd_span_counter
//   One axis (horizontal or vertical) of the raster. The count advances on
//   each cycle where step=1 and wraps from TOTAL-1 to 0.
//   Ports:
//     clk    in   clock
//     rst    in   synchronous reset, active-high
//     step   in   advance the count this cycle
//     count  out  W   current position (registered)
//     wrap   out  1   combinational: this step takes count from TOTAL-1 to 0
//     active out  1   registered: count lies in the visible region
//     sync   out  1   registered sync level for count, polarity POL
//   active/sync are computed from the next count so that they always
//   describe the same position that count shows.
module lcd_span_counter #(
  parameter int ACTIVE = 480,
  parameter int FP     = 2,
  parameter int SYNC   = 41,
  parameter int BP     = 2,
  parameter int POL    = 0,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int            TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0]  LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0]  ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0]  SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0]  SYNC_END   = W'(ACTIVE + FP + SYNC);
  localparam logic          SYNC_ON    = (POL != 0);

  logic [W-1:0] count_next;

  always_comb begin
    wrap       = step && (count == LAST);
    count_next = count;
    if (step) begin
      count_next = wrap ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
      sync   <= ~SYNC_ON;
    end else begin
      count  <= count_next;
      active <= (count_next < ACT_END);
      sync   <= ((count_next >= SYNC_START) && (count_next < SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//   Raster timing generator for the 480x272 RGB LCD. Produces HSYNC, VSYNC,
//   DE and pixel coordinates; start/stop is frame aligned.
//   Ports:
//     clk          in   pixel clock
//     rst          in   synchronous reset, active-high
//     en           in   run request, sampled every cycle
//     hsync/vsync  out  sync outputs, polarity HS_POL/VS_POL
//     de           out  high on visible pixels only
//     h_cnt/v_cnt  out  current raster position
//     line_start   out  pulse at h_cnt==0 of every line
//     frame_start  out  pulse at pixel (0,0)
//     busy         out  high while a frame is in progress
//   The H counter steps whenever a frame is running; the V counter steps on
//   the H wrap. In IDLE both counters sit at 0, which is outside both sync
//   windows, so the sync outputs read inactive there without extra gating.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = PANEL_H_ACTIVE,
  parameter int H_FP     = PANEL_H_FP,
  parameter int H_SYNC   = PANEL_H_SYNC,
  parameter int H_BP     = PANEL_H_BP,
  parameter int V_ACTIVE = PANEL_V_ACTIVE,
  parameter int V_FP     = PANEL_V_FP,
  parameter int V_SYNC   = PANEL_V_SYNC,
  parameter int V_BP     = PANEL_V_BP,
  parameter int HS_POL   = PANEL_HS_POL,
  parameter int VS_POL   = PANEL_VS_POL,
  parameter int HW       = 10,
  parameter int VW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (HW < $clog2(H_TOTAL)) begin : g_hw_check
      $error("lcd_timing_gen: HW too small for H_TOTAL");
    end
    if (VW < $clog2(V_TOTAL)) begin : g_vw_check
      $error("lcd_timing_gen: VW too small for V_TOTAL");
    end
  endgenerate

  state_t state;
  logic   running;
  logic   h_wrap;
  logic   v_wrap;
  logic   h_active;
  logic   v_active;

  assign running = (state != IDLE);

  lcd_span_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(HW)
  ) u_h (
    .clk    (clk),
    .rst    (rst),
    .step   (running),
    .count  (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (hsync)
  );

  lcd_span_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(VW)
  ) u_v (
    .clk    (clk),
    .rst    (rst),
    .step   (h_wrap),
    .count  (v_cnt),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (vsync)
  );

  // busy is 0 for every IDLE pixel, which masks the counters' idle activity.
  assign de = busy & h_active & v_active;

  // v_wrap is only true on the last pixel of a running frame, so it marks
  // the one point where a frame may end or roll straight into the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state       <= RUN;
            busy        <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            busy        <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (v_wrap) begin
            state       <= en ? RUN : IDLE;
            busy        <= en;
            line_start  <= en;
            frame_start <= en;
          end else begin
            state       <= en ? RUN : DRAIN;
            busy        <= 1'b1;
            line_start  <= h_wrap;
            frame_start <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          line_start  <= 1'b0;
          frame_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen
//   Directed and randomized checks of lcd_timing_gen. A reduced-geometry
//   panel keeps frames short; an inverted-polarity copy runs on the same
//   stimulus, and a full-size 480x272 instance checks one real line.
//   Reference model: a running flag plus a linear pixel index inside the
//   frame; x/y are index mod/div H_TOTAL.
module tb_lcd_timing_gen;

  localparam int HA = 12, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6,  VF = 2, VS = 3, VB = 2, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic en_full = 1'b0;

  logic hs0, vs0, de0, ls0, fs0, busy0;
  logic [9:0] h0;
  logic [8:0] v0;
  logic hs1, vs1, de1, ls1, fs1, busy1;
  logic [9:0] h1;
  logic [8:0] v1;
  logic hsf, vsf, def, lsf, fsf, busyf;
  logic [9:0] hf;
  logic [8:0] vf;

  int checks = 0;
  int errors = 0;

  bit m_run = 1'b0;
  int m_p = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hsync(hs0), .vsync(vs0), .de(de0),
    .h_cnt(h0), .v_cnt(v0), .line_start(ls0), .frame_start(fs0), .busy(busy0)
  );

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1), .VS_POL(1)
  ) dut_inv (
    .clk(clk), .rst(rst), .en(en), .hsync(hs1), .vsync(vs1), .de(de1),
    .h_cnt(h1), .v_cnt(v1), .line_start(ls1), .frame_start(fs1), .busy(busy1)
  );

  lcd_timing_gen dut_full (
    .clk(clk), .rst(rst), .en(en_full), .hsync(hsf), .vsync(vsf), .de(def),
    .h_cnt(hf), .v_cnt(vf), .line_start(lsf), .frame_start(fsf), .busy(busyf)
  );

  // One clock: the model takes the same rst/en the DUT samples, then
  // outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0;
      m_p   = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_p   = 0;
      end
    end else if (m_p == FRAME - 1) begin
      m_p = 0;
      if (!en) m_run = 1'b0;
    end else begin
      m_p++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en_full = 1'b0;
    repeat (3) tick();
    checks++;
    if ({de0, hs0, vs0, h0, v0, busy0, ls0, fs0} !== {1'b0, 1'b1, 1'b1, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: de=%b hs=%b vs=%b h=%0d v=%0d busy=%b ls=%b fs=%b, want 0 1 1 0 0 0 0 0",
               de0, hs0, vs0, h0, v0, busy0, ls0, fs0);
    end
    checks++;
    if ({hs1, vs1, hsf, vsf} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_sync_levels: inv hs/vs=%b%b full hs/vs=%b%b, want 00 11", hs1, vs1, hsf, vsf);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({de0, hs0, vs0, h0, v0, busy0, ls0, fs0} !== {1'b0, 1'b1, 1'b1, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: de=%b hs=%b vs=%b h=%0d v=%0d busy=%b fs=%b, want reset values",
                 i, de0, hs0, vs0, h0, v0, busy0, fs0);
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_line();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1, de_last = -1;
    en_full = 1'b1;
    tick();
    checks++;
    if ({fsf, lsf, def, busyf, hf, vf} !== {4'b1111, 10'd0, 9'd0}) begin
      errors++;
      $display("FAIL full_first_pixel: fs=%b ls=%b de=%b busy=%b h=%0d v=%0d, want 1 1 1 1 0 0",
               fsf, lsf, def, busyf, hf, vf);
    end
    for (int i = 0; i < 525; i++) begin
      if (i > 0) tick();
      if (def) begin de_cnt++; de_last = int'(hf); end
      if (!hsf) begin
        if (hs_first < 0) hs_first = int'(hf);
        hs_last = int'(hf);
        hs_cnt++;
      end
    end
    tick();
    checks++;
    if (de_cnt != 480 || de_last != 479) begin
      errors++;
      $display("FAIL full_de_run: count=%0d last_h=%0d, want 480 479", de_cnt, de_last);
    end
    checks++;
    if (hs_cnt != 41 || hs_first != 482 || hs_last != 522) begin
      errors++;
      $display("FAIL full_hsync: count=%0d first=%0d last=%0d, want 41 482 522", hs_cnt, hs_first, hs_last);
    end
    checks++;
    if ({lsf, fsf, hf, vf} !== {1'b1, 1'b0, 10'd0, 9'd1}) begin
      errors++;
      $display("FAIL full_line_period: ls=%b fs=%b h=%0d v=%0d after 525 cycles, want 1 0 0 1", lsf, fsf, hf, vf);
    end
    en_full = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    $display("test_full_line done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_line();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1, hs1_cnt = 0;
    en = 1'b1;
    tick();
    checks++;
    if ({fs0, ls0, de0, busy0, h0, v0} !== {4'b1111, 10'd0, 9'd0}) begin
      errors++;
      $display("FAIL start_pixel: fs=%b ls=%b de=%b busy=%b h=%0d v=%0d, want 1 1 1 1 0 0",
               fs0, ls0, de0, busy0, h0, v0);
    end
    for (int i = 0; i < HT; i++) begin
      if (i > 0) tick();
      if (de0) de_cnt++;
      if (hs1) hs1_cnt++;
      if (!hs0) begin
        if (hs_first < 0) hs_first = int'(h0);
        hs_last = int'(h0);
        hs_cnt++;
      end
    end
    tick();
    checks++;
    if (de_cnt != HA) begin
      errors++;
      $display("FAIL line_de_count: got %0d, want %0d", de_cnt, HA);
    end
    checks++;
    if (hs_cnt != HS || hs_first != HA + HF || hs_last != HA + HF + HS - 1) begin
      errors++;
      $display("FAIL line_hsync: count=%0d first=%0d last=%0d, want %0d %0d %0d",
               hs_cnt, hs_first, hs_last, HS, HA + HF, HA + HF + HS - 1);
    end
    checks++;
    if (hs1_cnt != HS) begin
      errors++;
      $display("FAIL line_hsync_inv: high count=%0d, want %0d", hs1_cnt, HS);
    end
    checks++;
    if ({ls0, h0, v0} !== {1'b1, 10'd0, 9'd1}) begin
      errors++;
      $display("FAIL line_period: ls=%b h=%0d v=%0d, want 1 0 1", ls0, h0, v0);
    end
    $display("test_line done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_frame();
    int n = 0, de_cnt = 0, vs_cnt = 0, vs1_cnt = 0, vs_first = -1, vs_last = -1, bad_edges = 0;
    logic prev_vs;
    while (!fs0 && n < 2 * FRAME) begin tick(); n++; end
    checks++;
    if (!fs0) begin
      errors++;
      $display("FAIL frame_wait: frame_start=%b after %0d cycles, want 1", fs0, n);
    end
    prev_vs = vs0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      if (vs0 !== prev_vs && h0 != 10'd0) bad_edges++;
      prev_vs = vs0;
      if (de0) de_cnt++;
      if (vs1) vs1_cnt++;
      if (!vs0) begin
        if (vs_first < 0) vs_first = int'(v0);
        vs_last = int'(v0);
        vs_cnt++;
      end
    end
    tick();
    checks++;
    if (fs0 !== 1'b1 || h0 !== 10'd0 || v0 !== 9'd0) begin
      errors++;
      $display("FAIL frame_period: fs=%b h=%0d v=%0d after %0d cycles, want 1 0 0", fs0, h0, v0, FRAME);
    end
    checks++;
    if (de_cnt != HA * VA) begin
      errors++;
      $display("FAIL frame_de_count: got %0d, want %0d", de_cnt, HA * VA);
    end
    checks++;
    if (vs_cnt != VS * HT || vs_first != VA + VF || vs_last != VA + VF + VS - 1) begin
      errors++;
      $display("FAIL frame_vsync: cycles=%0d first=%0d last=%0d, want %0d %0d %0d",
               vs_cnt, vs_first, vs_last, VS * HT, VA + VF, VA + VF + VS - 1);
    end
    checks++;
    if (vs1_cnt != VS * HT) begin
      errors++;
      $display("FAIL frame_vsync_inv: high cycles=%0d, want %0d", vs1_cnt, VS * HT);
    end
    checks++;
    if (bad_edges != 0) begin
      errors++;
      $display("FAIL vsync_edge_align: %0d edges away from h_cnt=0, want 0", bad_edges);
    end
    $display("test_frame done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_drain();
    int n = 0, last_h = -1, last_v = -1, stray = 0, cyc = 0, drops = 0;
    while (!(v0 == 9'd3 && h0 == 10'd0) && n < 2 * FRAME) begin tick(); n++; end
    en = 1'b0;
    n = 0;
    while (busy0 && n < 2 * FRAME) begin
      last_h = int'(h0);
      last_v = int'(v0);
      tick();
      n++;
    end
    checks++;
    if (n != FRAME - 3 * HT) begin
      errors++;
      $display("FAIL drain_length: busy fell after %0d cycles, want %0d", n, FRAME - 3 * HT);
    end
    checks++;
    if (last_h != HT - 1 || last_v != VT - 1) begin
      errors++;
      $display("FAIL drain_last_pixel: (%0d,%0d), want (%0d,%0d)", last_h, last_v, HT - 1, VT - 1);
    end
    for (int i = 0; i < 50; i++) begin
      if (fs0 || busy0 || de0 || h0 != 10'd0 || v0 != 9'd0 || !hs0 || !vs0) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL drain_idle: %0d non-idle cycles after drain, want 0", stray);
    end
    en = 1'b1;
    tick();
    checks++;
    if (fs0 !== 1'b1) begin
      errors++;
      $display("FAIL restart: frame_start=%b, want 1", fs0);
    end
    while (cyc < 2 * FRAME) begin
      tick();
      cyc++;
      if (!busy0) drops++;
      if (fs0) break;
      if (v0 == 9'd3 && h0 == 10'd0) en = 1'b0;
      if (v0 == 9'd8 && h0 == 10'd0) en = 1'b1;
    end
    checks++;
    if (cyc != FRAME || drops != 0) begin
      errors++;
      $display("FAIL drain_resume: next frame_start after %0d cycles with %0d idle, want %0d and 0",
               cyc, drops, FRAME);
    end
    $display("test_drain done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    en = 1'b1;
    while (!(h0 == 10'd7 && v0 == 9'd4) && n < 2 * FRAME) begin tick(); n++; end
    checks++;
    if (h0 != 10'd7 || v0 != 9'd4) begin
      errors++;
      $display("FAIL mid_wait: reached (%0d,%0d), want (7,4)", h0, v0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({de0, hs0, vs0, h0, v0, busy0, ls0, fs0, hs1, vs1} !== {3'b011, 10'd0, 9'd0, 5'b00000}) begin
      errors++;
      $display("FAIL mid_reset: de=%b hs=%b vs=%b h=%0d v=%0d busy=%b ls=%b fs=%b inv=%b%b, want reset values",
               de0, hs0, vs0, h0, v0, busy0, ls0, fs0, hs1, vs1);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({fs0, ls0, de0, busy0, h0, v0} !== {4'b1111, 10'd0, 9'd0}) begin
      errors++;
      $display("FAIL mid_restart: fs=%b ls=%b de=%b busy=%b h=%0d v=%0d, want 1 1 1 1 0 0",
               fs0, ls0, de0, busy0, h0, v0);
    end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    int x, y, bad = 0;
    logic e_de, e_hs, e_vs, e_ls, e_fs;
    logic [9:0] e_h;
    logic [8:0] e_v;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      rst = ($urandom_range(0, 999) == 0);
      tick();
      x = m_run ? m_p % HT : 0;
      y = m_run ? m_p / HT : 0;
      e_h  = 10'(x);
      e_v  = 9'(y);
      e_de = m_run && x < HA && y < VA;
      e_hs = m_run && x >= HA + HF && x < HA + HF + HS;
      e_vs = m_run && y >= VA + VF && y < VA + VF + VS;
      e_ls = m_run && x == 0;
      e_fs = m_run && m_p == 0;
      checks++;
      if ({h0, v0, de0, hs0, vs0, ls0, fs0, busy0} !== {e_h, e_v, e_de, ~e_hs, ~e_vs, e_ls, e_fs, m_run}
          || {h1, v1, de1, hs1, vs1, ls1, fs1, busy1} !== {e_h, e_v, e_de, e_hs, e_vs, e_ls, e_fs, m_run}) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b busy=%b (inv hs=%b vs=%b), want h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b busy=%b",
                   i, h0, v0, de0, hs0, vs0, ls0, fs0, busy0, hs1, vs1,
                   e_h, e_v, e_de, ~e_hs, ~e_vs, e_ls, e_fs, m_run);
      end
    end
    rst = 1'b0;
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_line();
    test_frame();
    test_drain();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
